// File: rtl/exu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : exu_issue_ctrl_if
// Brief   : IDU / MDU / WB / halt signal bundle for exu_issue_ctrl
// Revision: 1.0 - initial release
// ============================================================================
interface exu_issue_ctrl_if #(
   parameter int PC_W = 64
);
   logic            in_valid_i;
   logic            in_ready_o;
   logic [PC_W-1:0] in_pc_i;
   logic            in_is_mul_i;
   logic            in_is_div_i;
   logic            in_ebreak_i;
   logic            in_invalid_i;
   logic            mdu_start_o;
   logic            mdu_op_o;
   logic            mdu_done_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [PC_W-1:0] out_pc_o;
   logic            halt_o;
   logic [1:0]      halt_code_o;
   logic [PC_W-1:0] halt_pc_o;

   // The controller is the slave; the surrounding pipeline/harness is the master.
   modport slave (
      input  in_valid_i, in_pc_i, in_is_mul_i, in_is_div_i, in_ebreak_i,
             in_invalid_i, mdu_done_i, out_ready_i,
      output in_ready_o, mdu_start_o, mdu_op_o, out_valid_o, out_pc_o,
             halt_o, halt_code_o, halt_pc_o
   );

   modport master (
      output in_valid_i, in_pc_i, in_is_mul_i, in_is_div_i, in_ebreak_i,
             in_invalid_i, mdu_done_i, out_ready_i,
      input  in_ready_o, mdu_start_o, mdu_op_o, out_valid_o, out_pc_o,
             halt_o, halt_code_o, halt_pc_o
   );
endinterface
`default_nettype wire

// File: rtl/exu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : exu_issue_ctrl
// Brief   : Issue/sequencing controller: ALU pass-through, MDU wait, sticky halt
// Revision: 1.0 - initial release
// ============================================================================
module exu_issue_ctrl #(
   parameter int PC_W    = 64,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   exu_issue_ctrl_if.slave    bus
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUSY     = 2'd1,
      S_WAIT_OUT = 2'd2,
      S_HALT     = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mdu_op_q, mdu_op_d;
   logic [PC_W-1:0]  out_pc_q, out_pc_d;
   logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
   logic [1:0]       halt_code_q, halt_code_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mdu_op_q    <= 1'b0;
         out_pc_q    <= '0;
         halt_pc_q   <= '0;
         halt_code_q <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mdu_op_q    <= mdu_op_d;
         out_pc_q    <= out_pc_d;
         halt_pc_q   <= halt_pc_d;
         halt_code_q <= halt_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mdu_op_d    = mdu_op_q;
      out_pc_d    = out_pc_q;
      halt_pc_d   = halt_pc_q;
      halt_code_d = halt_code_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid_i) begin
               if (bus.in_invalid_i) begin
                  state_d     = S_HALT;
                  halt_code_d = 2'b11;
                  halt_pc_d   = bus.in_pc_i;
               end else if (bus.in_ebreak_i) begin
                  state_d     = S_HALT;
                  halt_code_d = 2'b01;
                  halt_pc_d   = bus.in_pc_i;
               end else if (bus.in_is_div_i || bus.in_is_mul_i) begin
                  state_d  = S_BUSY;
                  mdu_op_d = bus.in_is_div_i;
                  cnt_d    = '0;
                  out_pc_d = bus.in_pc_i;
               end else begin
                  state_d  = S_WAIT_OUT;
                  out_pc_d = bus.in_pc_i;
               end
            end
         end
         S_BUSY: begin
            // Counter stops advancing once BUSY is left, so it never wraps.
            cnt_d = cnt_q + 1'b1;
            if (bus.mdu_done_i) begin
               state_d = S_WAIT_OUT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = S_HALT;
               halt_code_d = 2'b10;
               halt_pc_d   = out_pc_q;
            end
         end
         S_WAIT_OUT: begin
            if (bus.out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // The start pulse is the first BUSY cycle: the counter is zero only there.
   assign bus.in_ready_o  = (state_q == S_IDLE);
   assign bus.mdu_start_o = (state_q == S_BUSY) && (cnt_q == '0);
   assign bus.mdu_op_o    = mdu_op_q;
   assign bus.out_valid_o = (state_q == S_WAIT_OUT);
   assign bus.out_pc_o    = out_pc_q;
   assign bus.halt_o      = (state_q == S_HALT);
   assign bus.halt_code_o = halt_code_q;
   assign bus.halt_pc_o   = halt_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_exu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_exu_issue_ctrl
// Brief   : Directed self-checking bench for exu_issue_ctrl
// Revision: 1.0 - initial release
// ============================================================================
module tb_exu_issue_ctrl;

   localparam int PC_W    = 64;
   localparam int TIMEOUT = 64;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   exu_issue_ctrl_if #(.PC_W(PC_W)) bus ();

   exu_issue_ctrl #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.in_valid_i   = 1'b0;
      bus.in_pc_i      = '0;
      bus.in_is_mul_i  = 1'b0;
      bus.in_is_div_i  = 1'b0;
      bus.in_ebreak_i  = 1'b0;
      bus.in_invalid_i = 1'b0;
      bus.mdu_done_i   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.out_ready_i = 1'b0;
      do_reset();
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready_o); end
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.mdu_start_o !== 1'b0) begin errors++; $display("FAIL rst_mdu_start: got %b want 0", bus.mdu_start_o); end
      checks++; if (bus.mdu_op_o !== 1'b0) begin errors++; $display("FAIL rst_mdu_op: got %b want 0", bus.mdu_op_o); end
      checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL rst_halt: got %b want 0", bus.halt_o); end
      checks++; if (bus.halt_code_o !== 2'b00) begin errors++; $display("FAIL rst_halt_code: got %b want 00", bus.halt_code_o); end
      checks++; if (bus.out_pc_o !== 64'h0) begin errors++; $display("FAIL rst_out_pc: got %h want 0", bus.out_pc_o); end
      checks++; if (bus.halt_pc_o !== 64'h0) begin errors++; $display("FAIL rst_halt_pc: got %h want 0", bus.halt_pc_o); end
   endtask

   task automatic test_alu();
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0000;
      tick();
      bus.in_valid_i  = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL alu_out_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.out_pc_o !== 64'h8000_0000) begin errors++; $display("FAIL alu_out_pc: got %h want 80000000", bus.out_pc_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL alu_in_ready_busy: got %b want 0", bus.in_ready_o); end
      checks++; if (bus.mdu_start_o !== 1'b0) begin errors++; $display("FAIL alu_no_start: got %b want 0", bus.mdu_start_o); end
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL alu_out_valid_drop: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL alu_in_ready_back: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_backpressure();
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0004;
      tick();
      // A different instruction stays presented; it must not disturb the held result.
      bus.in_pc_i     = 64'h8000_0BAD;
      bus.in_is_div_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid_o); end
         checks++; if (bus.out_pc_o !== 64'h8000_0004) begin errors++; $display("FAIL bp_out_pc[%0d]: got %h want 80000004", i, bus.out_pc_o); end
         checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready_o); end
         tick();
      end
      idle_inputs();
      bus.out_ready_i = 1'b1;
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_div();
      int starts;
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0010;
      bus.in_is_div_i = 1'b1;
      bus.in_is_mul_i = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bus.mdu_start_o !== 1'b1) begin errors++; $display("FAIL div_start: got %b want 1", bus.mdu_start_o); end
      checks++; if (bus.mdu_op_o !== 1'b1) begin errors++; $display("FAIL div_op: got %b want 1", bus.mdu_op_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL div_in_ready: got %b want 0", bus.in_ready_o); end
      starts = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.mdu_start_o === 1'b1) starts++;
         checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL div_early_valid[%0d]: got %b want 0", i, bus.out_valid_o); end
      end
      bus.mdu_done_i = 1'b1;
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (starts !== 1) begin errors++; $display("FAIL div_start_count: got %0d want 1", starts); end
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL div_out_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.out_pc_o !== 64'h8000_0010) begin errors++; $display("FAIL div_out_pc: got %h want 80000010", bus.out_pc_o); end
      tick();
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL div_back_idle: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_done_in_start_cycle();
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0030;
      bus.in_is_mul_i = 1'b1;
      tick();
      idle_inputs();
      bus.mdu_done_i = 1'b1;
      checks++; if (bus.mdu_op_o !== 1'b0) begin errors++; $display("FAIL mul_op: got %b want 0", bus.mdu_op_o); end
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL quick_done_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.out_pc_o !== 64'h8000_0030) begin errors++; $display("FAIL quick_done_pc: got %h want 80000030", bus.out_pc_o); end
      tick();
      // A stray done while idle must not produce a result.
      bus.mdu_done_i = 1'b1;
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL idle_done_ready: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_done_at_limit();
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0040;
      bus.in_is_mul_i = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL limit_pre_halt: got %b want 0", bus.halt_o); end
      bus.mdu_done_i = 1'b1;
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL limit_done_valid: got %b want 1", bus.out_valid_o); end
      checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL limit_done_halt: got %b want 0", bus.halt_o); end
      tick();
   endtask

   task automatic test_timeout();
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0050;
      bus.in_is_mul_i = 1'b1;
      tick();
      idle_inputs();
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL to_early_halt: got %b want 0", bus.halt_o); end
      tick();
      checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL to_halt: got %b want 1", bus.halt_o); end
      checks++; if (bus.halt_code_o !== 2'b10) begin errors++; $display("FAIL to_code: got %b want 10", bus.halt_code_o); end
      checks++; if (bus.halt_pc_o !== 64'h8000_0050) begin errors++; $display("FAIL to_pc: got %h want 80000050", bus.halt_pc_o); end
      checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL to_in_ready: got %b want 0", bus.in_ready_o); end
      bus.mdu_done_i = 1'b1;
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL to_late_done: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", bus.halt_o); end
   endtask

   task automatic test_reset_mid_busy();
      do_reset();
      bus.out_ready_i = 1'b1;
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0060;
      bus.in_is_div_i = 1'b1;
      tick();
      idle_inputs();
      tick();
      tick();
      do_reset();
      checks++; if (bus.halt_o !== 1'b0) begin errors++; $display("FAIL rmb_halt: got %b want 0", bus.halt_o); end
      checks++; if (bus.mdu_start_o !== 1'b0) begin errors++; $display("FAIL rmb_start: got %b want 0", bus.mdu_start_o); end
      checks++; if (bus.mdu_op_o !== 1'b0) begin errors++; $display("FAIL rmb_op: got %b want 0", bus.mdu_op_o); end
      checks++; if (bus.out_pc_o !== 64'h0) begin errors++; $display("FAIL rmb_out_pc: got %h want 0", bus.out_pc_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rmb_idle: got %b want 1", bus.in_ready_o); end
      bus.mdu_done_i = 1'b1;
      tick();
      bus.mdu_done_i = 1'b0;
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rmb_late_done: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL rmb_still_idle: got %b want 1", bus.in_ready_o); end
   endtask

   task automatic test_halt_priority();
      bus.in_valid_i   = 1'b1;
      bus.in_pc_i      = 64'h8000_0024;
      bus.in_ebreak_i  = 1'b1;
      bus.in_invalid_i = 1'b1;
      bus.in_is_mul_i  = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bus.halt_o !== 1'b1) begin errors++; $display("FAIL inv_halt: got %b want 1", bus.halt_o); end
      checks++; if (bus.halt_code_o !== 2'b11) begin errors++; $display("FAIL inv_code: got %b want 11", bus.halt_code_o); end
      checks++; if (bus.halt_pc_o !== 64'h8000_0024) begin errors++; $display("FAIL inv_pc: got %h want 80000024", bus.halt_pc_o); end
      checks++; if (bus.mdu_start_o !== 1'b0) begin errors++; $display("FAIL inv_no_start: got %b want 0", bus.mdu_start_o); end
      bus.in_valid_i = 1'b1;
      bus.in_pc_i    = 64'h8000_0100;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL inv_ignore_valid: got %b want 0", bus.out_valid_o); end
      checks++; if (bus.halt_pc_o !== 64'h8000_0024) begin errors++; $display("FAIL inv_pc_stable: got %h want 80000024", bus.halt_pc_o); end
      checks++; if (bus.halt_code_o !== 2'b11) begin errors++; $display("FAIL inv_code_stable: got %b want 11", bus.halt_code_o); end
      idle_inputs();
      do_reset();
      bus.in_valid_i  = 1'b1;
      bus.in_pc_i     = 64'h8000_0028;
      bus.in_ebreak_i = 1'b1;
      bus.in_is_div_i = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bus.halt_code_o !== 2'b01) begin errors++; $display("FAIL ebreak_code: got %b want 01", bus.halt_code_o); end
      checks++; if (bus.halt_pc_o !== 64'h8000_0028) begin errors++; $display("FAIL ebreak_pc: got %h want 80000028", bus.halt_pc_o); end
      checks++; if (bus.mdu_start_o !== 1'b0) begin errors++; $display("FAIL ebreak_no_start: got %b want 0", bus.mdu_start_o); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      bus.out_ready_i = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_alu();
      test_backpressure();
      test_div();
      test_done_in_start_cycle();
      test_done_at_limit();
      test_timeout();
      test_reset_mid_busy();
      test_halt_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
